// File: rtl/alu_seq_pkg.sv
// Shared types and helpers for the multi-word ALU sequencer.
// State encoding, chain-mode op codes and the chain-mode predicate.
package alu_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [3:0] MODE_ADD = 4'b0000;
    localparam logic [3:0] MODE_SUB = 4'b0001;

    function automatic logic is_chain(input logic [3:0] m);
        return (m == MODE_ADD) || (m == MODE_SUB);
    endfunction

endpackage

// File: rtl/Modified_ALU_Nbit.sv
// Combinational N-bit ALU with carry/borrow in and out.
// Modes 0000/0001 chain through CB; the rest operate on one word only.
module Modified_ALU_Nbit #(
    parameter int N = 4
) (
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic [3:0]   Mode,
    input  logic         CB_in,
    output logic [N-1:0] Result,
    output logic         CB_out
);

    logic [N:0] sum;
    logic [N:0] dif;
    logic [N:0] add2;
    logic [N:0] sub2;

    always_comb begin
        sum  = {1'b0, A} + {1'b0, B} + {{N{1'b0}}, CB_in};
        dif  = {1'b0, A} - {1'b0, B} - {{N{1'b0}}, CB_in};
        add2 = {1'b0, A} + {1'b0, B};
        sub2 = {1'b0, A} - {1'b0, B};
        Result = '0;
        CB_out = 1'b0;
        case (Mode)
            4'b0000: {CB_out, Result} = sum;
            4'b0001: {CB_out, Result} = dif;
            4'b0010: Result = A & B;
            4'b0011: Result = A | B;
            4'b0100: Result = A ^ B;
            4'b0101: Result = ~(A & B);
            4'b0110: Result = ~(A | B);
            4'b0111: Result = ~(A ^ B);
            4'b1000: Result = ~A;
            4'b1001: Result = A;
            4'b1010: Result = B;
            4'b1011: {CB_out, Result} = add2;
            4'b1100: {CB_out, Result} = sub2;
            4'b1101: begin
                Result = {A[N-2:0], 1'b0};
                CB_out = A[N-1];
            end
            4'b1110: begin
                Result = {1'b0, A[N-1:1]};
                CB_out = A[0];
            end
            default: Result = ~B;
        endcase
    end

endmodule

// File: rtl/alu_multiword_top.sv
// Pairs the multi-word sequencer with the team's N-bit ALU.
// Exposes only the wide-operand request/response side.
module alu_multiword_top #(
    parameter  int N     = 4,
    parameter  int WORDS = 4,
    localparam int W     = N * WORDS
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [3:0]   mode,
    input  logic [W-1:0] op_a,
    input  logic [W-1:0] op_b,
    input  logic         cb_init,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] result,
    output logic         cb_final
);

    logic [N-1:0] alu_a;
    logic [N-1:0] alu_b;
    logic [3:0]   alu_mode;
    logic         alu_cb_in;
    logic [N-1:0] alu_result;
    logic         alu_cb_out;

    alu_multiword_seq #(
        .N     (N),
        .WORDS (WORDS)
    ) u_seq (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .mode       (mode),
        .op_a       (op_a),
        .op_b       (op_b),
        .cb_init    (cb_init),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .cb_final   (cb_final),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_mode   (alu_mode),
        .alu_cb_in  (alu_cb_in),
        .alu_result (alu_result),
        .alu_cb_out (alu_cb_out)
    );

    Modified_ALU_Nbit #(
        .N (N)
    ) u_alu (
        .A      (alu_a),
        .B      (alu_b),
        .Mode   (alu_mode),
        .CB_in  (alu_cb_in),
        .Result (alu_result),
        .CB_out (alu_cb_out)
    );

endmodule

// File: rtl/alu_multiword_seq.sv
// Drives an external N-bit ALU one word per clock, LSW first,
// chaining carry/borrow across words for wide add and subtract.
module alu_multiword_seq
    import alu_seq_pkg::*;
#(
    parameter  int N     = 4,
    parameter  int WORDS = 4,
    localparam int W     = N * WORDS
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [3:0]   mode,
    input  logic [W-1:0] op_a,
    input  logic [W-1:0] op_b,
    input  logic         cb_init,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] result,
    output logic         cb_final,
    output logic [N-1:0] alu_a,
    output logic [N-1:0] alu_b,
    output logic [3:0]   alu_mode,
    output logic         alu_cb_in,
    input  logic [N-1:0] alu_result,
    input  logic         alu_cb_out
);

    localparam int IW = $clog2(WORDS);
    localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

    state_e         state_q, state_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic [3:0]     mode_q, mode_d;
    logic [W-1:0]   a_q, a_d;
    logic [W-1:0]   b_q, b_d;
    logic [W-1:0]   res_q, res_d;
    logic           cb_q, cb_d;
    logic           cbf_q, cbf_d;
    logic           chain;

    assign chain = is_chain(mode_q);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        mode_d  = mode_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        cb_d    = cb_q;
        cbf_d   = cbf_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    idx_d   = '0;
                    mode_d  = mode;
                    a_d     = op_a;
                    b_d     = op_b;
                    cb_d    = is_chain(mode) ? cb_init : 1'b0;
                end
            end
            RUN: begin
                res_d[idx_q*N +: N] = alu_result;
                // Select keeps an unknown CB_out out of the register.
                cb_d = chain ? alu_cb_out : 1'b0;
                if (idx_q == LAST) begin
                    state_d = DONE;
                    cbf_d   = cb_d;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            mode_q  <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            cb_q    <= 1'b0;
            cbf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            mode_q  <= mode_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            cb_q    <= cb_d;
            cbf_q   <= cbf_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign result    = res_q;
    assign cb_final  = cbf_q;
    assign alu_mode  = mode_q;
    assign alu_a     = (state_q == RUN) ? a_q[idx_q*N +: N] : '0;
    assign alu_b     = (state_q == RUN) ? b_q[idx_q*N +: N] : '0;
    assign alu_cb_in = (state_q == RUN) ? cb_q : 1'b0;

endmodule
